// File: rtl/seg_disp_pkg.sv
// Shared constants for the HH:MM seven-segment display stage: segment LUT,
// digit slot indices and controller state encoding.
package seg_disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIG_W      = 2;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned TENS_W     = 3;

  localparam logic [DIG_W-1:0] DIG_MIN1  = 2'd0;
  localparam logic [DIG_W-1:0] DIG_MIN10 = 2'd1;
  localparam logic [DIG_W-1:0] DIG_HR1   = 2'd2;
  localparam logic [DIG_W-1:0] DIG_HR10  = 2'd3;

  // Active-low {g,f,e,d,c,b,a}; element 0 is the glyph for digit 0
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [9:0][SEG_W-1:0] SEG_LUT = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONV_MIN = 2'd1,
    CONV_HR  = 2'd2,
    COMMIT   = 2'd3
  } ctrl_state_e;

  function automatic logic [SEG_W-1:0] seg_encode(input logic [BCD_W-1:0] d);
    logic [SEG_W-1:0] s;
    s = SEG_BLANK;
    if (d <= 4'd9) s = SEG_LUT[d];
    return s;
  endfunction

endpackage

// File: rtl/seg_clock_display_bin2bcd.sv
// Sequential double-dabble: binary in, 3-bit tens / 4-bit ones BCD out.
// done pulses WIDTH cycles after start; results hold until the next start.
module bin2bcd_seq
  import seg_disp_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  bin,
  output logic              done,
  output logic [TENS_W-1:0] tens,
  output logic [BCD_W-1:0]  ones
);

  localparam int unsigned SR_W  = TENS_W + BCD_W + WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [SR_W-1:0]  sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  // One add-3/shift iteration; tens never reaches 5 before the final shift for 6-bit input
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] a;
    a = v;
    if (a[WIDTH+3:WIDTH] >= 4'd5) a[WIDTH+3:WIDTH] = a[WIDTH+3:WIDTH] + 4'd3;
    return a << 1;
  endfunction

  // The load edge already performs the first iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start && !busy_q) begin
        sr_q   <= dd_step({(TENS_W + BCD_W)'(0), bin});
        cnt_q  <= CNT_W'(WIDTH - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        sr_q  <= dd_step(sr_q);
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign tens = sr_q[SR_W-1 -: TENS_W];
  assign ones = sr_q[WIDTH +: BCD_W];

endmodule

// File: rtl/seg_clock_display.sv
// Multiplexed HH:MM common-anode display driver. Inputs are snapshotted once per
// scan frame, converted to BCD, and committed to the digit registers together.
module seg_clock_display
  import seg_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic             clk_100Mhz,
  input  logic             reset,
  input  logic [3:0]       hours,
  input  logic [5:0]       minutes,
  input  logic             sig_1Hz,
  output logic [3:0]       an,
  output logic [SEG_W-1:0] seg,
  output logic             dp
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  if (SCAN_DIV < 32) begin : g_bad_scan_div
    $error("seg_clock_display: SCAN_DIV must be >= 32");
  end

  logic [CNT_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [DIG_W-1:0]  digit_idx_q, digit_idx_d;
  logic              tick_c, cap_evt_c, commit_c;
  logic [1:0]        sync_q;
  ctrl_state_e       state_q;
  logic              start_q;
  logic [3:0]        hours_cap_q;
  logic [5:0]        min_cap_q;
  logic [TENS_W-1:0] min_tens_tmp_q, min_tens_q, min_tens_d, hr_tens_q, hr_tens_d;
  logic [BCD_W-1:0]  min_ones_tmp_q, min_ones_q, min_ones_d, hr_ones_q, hr_ones_d;
  logic [5:0]        conv_bin_c;
  logic              conv_done;
  logic [TENS_W-1:0] conv_tens;
  logic [BCD_W-1:0]  conv_ones;
  logic [BCD_W-1:0]  cur_digit_c;
  logic              blank_c;
  logic [3:0]        an_d;
  logic [SEG_W-1:0]  seg_d;
  logic              dp_d;

  assign tick_c      = (scan_cnt_q == CNT_W'(SCAN_DIV - 1));
  assign cap_evt_c   = tick_c && (digit_idx_q == DIG_HR10);
  assign scan_cnt_d  = tick_c ? '0 : scan_cnt_q + CNT_W'(1);
  assign digit_idx_d = tick_c ? digit_idx_q + DIG_W'(1) : digit_idx_q;
  assign conv_bin_c  = (state_q == CONV_HR) ? {2'b00, hours_cap_q} : min_cap_q;
  assign commit_c    = (state_q == COMMIT);

  bin2bcd_seq #(.WIDTH(6)) u_bcd (
    .clk   (clk_100Mhz),
    .rst_n (reset),
    .start (start_q),
    .bin   (conv_bin_c),
    .done  (conv_done),
    .tens  (conv_tens),
    .ones  (conv_ones)
  );

  // Capture, minutes conversion, hours conversion, then a one-cycle commit
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      start_q        <= 1'b0;
      hours_cap_q    <= '0;
      min_cap_q      <= '0;
      min_tens_tmp_q <= '0;
      min_ones_tmp_q <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: if (cap_evt_c) begin
          hours_cap_q <= hours;
          min_cap_q   <= minutes;
          start_q     <= 1'b1;
          state_q     <= CONV_MIN;
        end
        CONV_MIN: if (conv_done) begin
          min_tens_tmp_q <= conv_tens;
          min_ones_tmp_q <= conv_ones;
          start_q        <= 1'b1;
          state_q        <= CONV_HR;
        end
        CONV_HR: if (conv_done) state_q <= COMMIT;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Digit register next-state; the output stage also reads these so a commit shows on the same edge
  always_comb begin
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    hr_ones_d  = hr_ones_q;
    hr_tens_d  = hr_tens_q;
    if (commit_c) begin
      min_ones_d = min_ones_tmp_q;
      min_tens_d = min_tens_tmp_q;
      hr_ones_d  = conv_ones;
      hr_tens_d  = conv_tens;
    end
  end

  always_comb begin
    cur_digit_c = '0;
    case (digit_idx_q)
      DIG_MIN1:  cur_digit_c = min_ones_d;
      DIG_MIN10: cur_digit_c = BCD_W'(min_tens_d);
      DIG_HR1:   cur_digit_c = hr_ones_d;
      default:   cur_digit_c = BCD_W'(hr_tens_d);
    endcase
    blank_c = BLANK_LZ && (digit_idx_q == DIG_HR10) && (hr_tens_d == '0);
    an_d    = blank_c ? 4'b1111 : ~(4'b0001 << digit_idx_q);
    seg_d   = blank_c ? SEG_BLANK : seg_encode(cur_digit_c);
    dp_d    = !((digit_idx_q == DIG_HR1) && sync_q[1]);
  end

  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      sync_q      <= '0;
      min_ones_q  <= '0;
      min_tens_q  <= '0;
      hr_ones_q   <= '0;
      hr_tens_q   <= '0;
      an          <= 4'b1111;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      sync_q      <= {sync_q[0], sig_1Hz};
      min_ones_q  <= min_ones_d;
      min_tens_q  <= min_tens_d;
      hr_ones_q   <= hr_ones_d;
      hr_tens_q   <= hr_tens_d;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg_clock_display.sv
// Directed bench for seg_clock_display with SCAN_DIV=32; a second instance runs
// with leading-zero blanking disabled.
module tb_seg_clock_display;

  localparam int unsigned SCAN_DIV = 32;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010, S9 = 7'b0010000, SOFF = 7'b1111111;
  localparam logic [11:0] ALL_OFF = {4'b1111, SOFF, 1'b1};

  logic       clk_100Mhz = 1'b0;
  logic       rst_n;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic       sig_1Hz;
  logic [3:0] an, an_nb;
  logic [6:0] seg, seg_nb;
  logic       dp, dp_nb;

  int unsigned edge_n;
  int          checks = 0;
  int          failures = 0;

  always #5 clk_100Mhz = ~clk_100Mhz;

  seg_clock_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut (
    .clk_100Mhz (clk_100Mhz),
    .reset      (rst_n),
    .hours      (hours),
    .minutes    (minutes),
    .sig_1Hz    (sig_1Hz),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  seg_clock_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_nb (
    .clk_100Mhz (clk_100Mhz),
    .reset      (rst_n),
    .hours      (hours),
    .minutes    (minutes),
    .sig_1Hz    (sig_1Hz),
    .an         (an_nb),
    .seg        (seg_nb),
    .dp         (dp_nb)
  );

  // Edges since reset release; after edge k the outputs show slot ((k-1)/32)%4
  always @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  task automatic wait_edge(input int unsigned k);
    while (edge_n < k) begin
      @(posedge clk_100Mhz);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: an/seg/dp observed %b/%b/%b expected %b/%b/%b",
             tag, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    hours   = 4'($urandom);
    minutes = 6'($urandom);
    sig_1Hz = 1'($urandom);
    repeat (3) @(posedge clk_100Mhz);
    #1;
    chk("rst_off", {an, seg, dp}, ALL_OFF);
    chk("rst_off_nb", {an_nb, seg_nb, dp_nb}, ALL_OFF);
    hours   = 4'($urandom);
    minutes = 6'($urandom);
    sig_1Hz = 1'b1;
    repeat (3) @(posedge clk_100Mhz);
    #1;
    chk("rst_off_sig", {an, seg, dp}, ALL_OFF);

    @(negedge clk_100Mhz);
    rst_n   = 1'b1;
    hours   = 4'd12;
    minutes = 6'd34;
    sig_1Hz = 1'b0;

    wait_edge(1);   chk("rel_d0", {an, seg, dp}, {4'b1110, S0, 1'b1});
    wait_edge(33);  chk("rel_d1", {an, seg, dp}, {4'b1101, S0, 1'b1});
    wait_edge(97);  chk("rel_d3_blank", {an, seg, dp}, ALL_OFF);
    chk("rel_d3_nb", {an_nb, seg_nb, dp_nb}, {4'b0111, S0, 1'b1});

    // 12:34 captured at edge 128, visible from edge 143
    wait_edge(142); chk("t2_pre_commit", {an, seg, dp}, {4'b1110, S0, 1'b1});
    wait_edge(143); chk("t2_d0", {an, seg, dp}, {4'b1110, S4, 1'b1});
    wait_edge(161); chk("t2_d1", {an, seg, dp}, {4'b1101, S3, 1'b1});
    wait_edge(170); minutes = 6'd35;
    wait_edge(193); chk("t2_d2", {an, seg, dp}, {4'b1011, S2, 1'b1});
    wait_edge(225); chk("t2_d3", {an, seg, dp}, {4'b0111, S1, 1'b1});

    // 35 captured at edge 256
    wait_edge(270); chk("t4_hold", {an, seg, dp}, {4'b1110, S4, 1'b1});
    wait_edge(271); chk("t4_new", {an, seg, dp}, {4'b1110, S5, 1'b1});
    wait_edge(280); hours = 4'd9; minutes = 6'd5;

    // 09:05 captured at edge 384
    wait_edge(399); chk("t3_d0", {an, seg, dp}, {4'b1110, S5, 1'b1});
    wait_edge(417); chk("t3_d1", {an, seg, dp}, {4'b1101, S0, 1'b1});
    wait_edge(449); chk("t3_d2", {an, seg, dp}, {4'b1011, S9, 1'b1});
    wait_edge(481); chk("t3_d3_blank", {an, seg, dp}, ALL_OFF);
    chk("t3_d3_nb", {an_nb, seg_nb, dp_nb}, {4'b0111, S0, 1'b1});

    // Colon: sig_1Hz rises inside an hours-ones slot
    wait_edge(580); sig_1Hz = 1'b1;
    wait_edge(582); chk("t5_sync_lag", {an, seg, dp}, {4'b1011, S9, 1'b1});
    wait_edge(583); chk("t5_colon_on", {an, seg, dp}, {4'b1011, S9, 1'b0});
    wait_edge(608); chk("t5_colon_end", {an, seg, dp}, {4'b1011, S9, 1'b0});
    wait_edge(609); chk("t5_d3_nodp", {an, seg, dp}, ALL_OFF);
    chk("t5_d3_nb_nodp", {an_nb, seg_nb, dp_nb}, {4'b0111, S0, 1'b1});
    wait_edge(641); chk("t5_d0_nodp", {an, seg, dp}, {4'b1110, S5, 1'b1});
    wait_edge(650); sig_1Hz = 1'b0;
    wait_edge(705); chk("t5_colon_off", {an, seg, dp}, {4'b1011, S9, 1'b1});

    // Reset during the hours conversion of the capture at edge 768
    wait_edge(710); hours = 4'd7; minutes = 6'd41;
    wait_edge(778);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_async", {an, seg, dp}, ALL_OFF);
    chk("t6_rst_async_nb", {an_nb, seg_nb, dp_nb}, ALL_OFF);
    hours   = 4'd3;
    minutes = 6'd59;
    repeat (2) @(negedge clk_100Mhz);
    rst_n = 1'b1;

    wait_edge(1);   chk("t6_cleared_d0", {an, seg, dp}, {4'b1110, S0, 1'b1});
    wait_edge(97);  chk("t6_cleared_d3", {an, seg, dp}, ALL_OFF);
    wait_edge(142); chk("t6_pre_commit", {an, seg, dp}, {4'b1110, S0, 1'b1});
    wait_edge(143); chk("t6_d0", {an, seg, dp}, {4'b1110, S9, 1'b1});
    wait_edge(161); chk("t6_d1", {an, seg, dp}, {4'b1101, S5, 1'b1});
    wait_edge(193); chk("t6_d2", {an, seg, dp}, {4'b1011, S3, 1'b1});
    wait_edge(225); chk("t6_d3_blank", {an, seg, dp}, ALL_OFF);
    chk("t6_d3_nb", {an_nb, seg_nb, dp_nb}, {4'b0111, S0, 1'b1});

    // Out-of-range inputs display unclamped: 15:63
    wait_edge(230); hours = 4'd15; minutes = 6'd63;
    wait_edge(270); chk("bnd_hold", {an, seg, dp}, {4'b1110, S9, 1'b1});
    wait_edge(271); chk("bnd_d0", {an, seg, dp}, {4'b1110, S3, 1'b1});
    wait_edge(289); chk("bnd_d1", {an, seg, dp}, {4'b1101, S6, 1'b1});
    wait_edge(321); chk("bnd_d2", {an, seg, dp}, {4'b1011, S5, 1'b1});
    wait_edge(353); chk("bnd_d3", {an, seg, dp}, {4'b0111, S1, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
